// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the alu: register file with pending-write scoreboard,
// write-through bypass from the writeback port, and a valid/ready output register.
module alu_operand_stage #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_reg1,
  output logic [DATA_W-1:0] out_reg2,
  output logic [ADDR_W-1:0] out_rd
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  clr_vec;
  logic [NREGS-1:0]  set_vec;
  logic [NREGS-1:0]  busy;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] opnd1_p0;
  logic [DATA_W-1:0] opnd2_p0;

  logic              vld_p1;
  logic [OP_W-1:0]   op_p1;
  logic [DATA_W-1:0] reg1_p1;
  logic [DATA_W-1:0] reg2_p1;
  logic [ADDR_W-1:0] rd_p1;

  // Stage p0: hazard detection and operand selection
  always_comb begin
    clr_vec = '0;
    if (wb_en && (wb_addr != '0)) clr_vec[wb_addr] = 1'b1;
    // A register whose writeback lands this cycle is no longer a hazard.
    busy = pend & ~clr_vec;
    hazard = busy[in_rs1]
           | (~in_use_imm & busy[in_rs2])
           | ((in_rd != '0) & busy[in_rd]);
    in_ready = (!vld_p1 || out_ready) && !hazard;
    accept   = in_valid && in_ready;

    set_vec = '0;
    if (accept && (in_rd != '0)) set_vec[in_rd] = 1'b1;

    if (in_rs1 == '0)                         opnd1_p0 = '0;
    else if (wb_en && (wb_addr == in_rs1))    opnd1_p0 = wb_data;
    else                                      opnd1_p0 = regs[in_rs1];

    if (in_use_imm)                           opnd2_p0 = in_imm;
    else if (in_rs2 == '0)                    opnd2_p0 = '0;
    else if (wb_en && (wb_addr == in_rs2))    opnd2_p0 = wb_data;
    else                                      opnd2_p0 = regs[in_rs2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      if (wb_en && (wb_addr != '0)) regs[wb_addr] <= wb_data;
      // set after clear so a simultaneous issue keeps the register pending
      pend <= (pend & ~clr_vec) | set_vec;
    end
  end

  // Stage p1: output register toward the alu
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      op_p1   <= '0;
      reg1_p1 <= '0;
      reg2_p1 <= '0;
      rd_p1   <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      op_p1   <= in_op;
      reg1_p1 <= opnd1_p0;
      reg2_p1 <= opnd2_p0;
      rd_p1   <= in_rd;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_op    = op_p1;
  assign out_reg1  = reg1_p1;
  assign out_reg2  = reg2_p1;
  assign out_rd    = rd_p1;

endmodule
